// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: shares one UDP transmit port between an audio/RTP requester
// and a control requester. Audio gets priority up to a burst limit, after which
// a pending control request wins. Each packet waits for udp_send_done (with a
// timeout) and is followed by an idle gap.
//
// state | meaning
// IDLE  | arbitrate between pending requests, validate length, grant
// WAIT  | packet presented to the UDP stack, waiting for done or timeout
// GAP   | enforced idle cycles before the next arbitration
module udp_tx_arbiter #(
  parameter int DATA_W          = 7680,
  parameter int GAP_CYCLES      = 64,
  parameter int TIMEOUT_CYCLES  = 1000000,
  parameter int MAX_AUDIO_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic [DATA_W-1:0] a_data,
  input  logic [15:0]       a_len,
  output logic              a_ack,
  output logic              a_err,
  input  logic              c_req,
  input  logic [DATA_W-1:0] c_data,
  input  logic [15:0]       c_len,
  output logic              c_ack,
  output logic              c_err,
  output logic              udp_send_data_valid,
  output logic [DATA_W-1:0] udp_send_data,
  output logic [15:0]       udp_send_data_length,
  input  logic              udp_send_done,
  output logic [1:0]        grant,
  output logic              busy
);

  localparam int TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int SW       = (MAX_AUDIO_BURST > 0) ? $clog2(MAX_AUDIO_BURST + 1) : 1;
  localparam int MAX_LEN  = DATA_W / 8;
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              valid_q, valid_d;
  logic [1:0]        grant_q, grant_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [15:0]       len_q, len_d;
  logic              a_ack_q, a_ack_d, a_err_q, a_err_d;
  logic              c_ack_q, c_ack_d, c_err_q, c_err_d;
  logic              busy_q;

  logic              sel_c;
  logic [15:0]       sel_len;
  logic              len_ok;
  logic              completing;

  // Selection and length validation of the request that would win this cycle
  always_comb begin
    sel_c      = c_req && (!a_req || (streak_q == SW'(MAX_AUDIO_BURST)));
    sel_len    = sel_c ? c_len : a_len;
    len_ok     = (sel_len != 16'd0) && ({16'd0, sel_len} <= 32'(MAX_LEN));
    // A requester still sees its own ack/err this cycle and may not have
    // dropped req yet, so no arbitration happens while a pulse is out.
    completing = a_ack_q | a_err_q | c_ack_q | c_err_q;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    gap_d    = gap_q;
    streak_d = streak_q;
    valid_d  = valid_q;
    grant_d  = grant_q;
    data_d   = data_q;
    len_d    = len_q;
    a_ack_d  = 1'b0;
    a_err_d  = 1'b0;
    c_ack_d  = 1'b0;
    c_err_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if ((a_req || c_req) && !completing) begin
          if (!len_ok) begin
            a_err_d = !sel_c;
            c_err_d = sel_c;
          end else begin
            data_d  = sel_c ? c_data : a_data;
            len_d   = sel_len;
            grant_d = sel_c ? 2'b10 : 2'b01;
            valid_d = 1'b1;
            timer_d = '0;
            state_d = S_WAIT;
            if (sel_c)
              streak_d = '0;
            else if (streak_q != SW'(MAX_AUDIO_BURST))
              streak_d = streak_q + SW'(1);
          end
        end
      end

      S_WAIT: begin
        if (udp_send_done || (timer_q == TW'(TIMEOUT_CYCLES - 1))) begin
          // done takes precedence when it coincides with the timeout
          valid_d = 1'b0;
          grant_d = 2'b00;
          a_ack_d = grant_q[0] && udp_send_done;
          c_ack_d = grant_q[1] && udp_send_done;
          a_err_d = grant_q[0] && !udp_send_done;
          c_err_d = grant_q[1] && !udp_send_done;
          if (GAP_CYCLES == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
            gap_d   = GW'(GAP_LOAD);
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_GAP: begin
        if (gap_q == '0)
          state_d = S_IDLE;
        else
          gap_d = gap_q - GW'(1);
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      gap_q    <= '0;
      streak_q <= '0;
      valid_q  <= 1'b0;
      grant_q  <= 2'b00;
      data_q   <= '0;
      len_q    <= '0;
      a_ack_q  <= 1'b0;
      a_err_q  <= 1'b0;
      c_ack_q  <= 1'b0;
      c_err_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      gap_q    <= gap_d;
      streak_q <= streak_d;
      valid_q  <= valid_d;
      grant_q  <= grant_d;
      data_q   <= data_d;
      len_q    <= len_d;
      a_ack_q  <= a_ack_d;
      a_err_q  <= a_err_d;
      c_ack_q  <= c_ack_d;
      c_err_q  <= c_err_d;
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign a_ack                = a_ack_q;
  assign a_err                = a_err_q;
  assign c_ack                = c_ack_q;
  assign c_err                = c_err_q;
  assign udp_send_data_valid  = valid_q;
  assign udp_send_data        = data_q;
  assign udp_send_data_length = len_q;
  assign grant                = grant_q;
  assign busy                 = busy_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Bench for udp_tx_arbiter: dut0 uses a 64-cycle gap, dut1 no gap; both use a
// 100-cycle timeout. Status vectors are {valid, grant[1:0], busy, a_ack,
// a_err, c_ack, c_err}.
module tb_udp_tx_arbiter;
  localparam int DW   = 7680;
  localparam int MAXB = 4;
  localparam int TMO  = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] a_data, c_data;
  logic [15:0]   a_len, c_len;

  logic          rst0, a_req0, c_req0, done0;
  logic          a_ack0, a_err0, c_ack0, c_err0, valid0, busy0;
  logic [DW-1:0] data0;
  logic [15:0]   len0;
  logic [1:0]    grant0;

  logic          rst1, a_req1, c_req1, done1;
  logic          a_ack1, a_err1, c_ack1, c_err1, valid1, busy1;
  logic [DW-1:0] data1;
  logic [15:0]   len1;
  logic [1:0]    grant1;

  logic [7:0] st0, st1;
  assign st0 = {valid0, grant0, busy0, a_ack0, a_err0, c_ack0, c_err0};
  assign st1 = {valid1, grant1, busy1, a_ack1, a_err1, c_ack1, c_err1};

  udp_tx_arbiter #(.DATA_W(DW), .GAP_CYCLES(64), .TIMEOUT_CYCLES(TMO),
                   .MAX_AUDIO_BURST(MAXB)) dut0 (
    .clk(clk), .rst(rst0),
    .a_req(a_req0), .a_data(a_data), .a_len(a_len), .a_ack(a_ack0), .a_err(a_err0),
    .c_req(c_req0), .c_data(c_data), .c_len(c_len), .c_ack(c_ack0), .c_err(c_err0),
    .udp_send_data_valid(valid0), .udp_send_data(data0),
    .udp_send_data_length(len0), .udp_send_done(done0),
    .grant(grant0), .busy(busy0));

  udp_tx_arbiter #(.DATA_W(DW), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TMO),
                   .MAX_AUDIO_BURST(MAXB)) dut1 (
    .clk(clk), .rst(rst1),
    .a_req(a_req1), .a_data(a_data), .a_len(a_len), .a_ack(a_ack1), .a_err(a_err1),
    .c_req(c_req1), .c_data(c_data), .c_len(c_len), .c_ack(c_ack1), .c_err(c_err1),
    .udp_send_data_valid(valid1), .udp_send_data(data1),
    .udp_send_data_length(len1), .udp_send_done(done1),
    .grant(grant1), .busy(busy1));

  int n_vec = 0;
  int n_bad = 0;

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [15:0] rand_len();
    case ($urandom_range(0, 5))
      0:       return 16'd0;
      1:       return 16'd961;
      2:       return 16'($urandom_range(962, 65535));
      default: return 16'($urandom_range(1, 960));
    endcase
  endfunction

  task automatic wait_idle0();
    int k = 0;
    while (busy0 && k < 300) begin
      step();
      k++;
    end
    n_vec++;
    if (busy0 !== 1'b0) begin
      n_bad++;
      $display("FAIL idle0_wait: busy=%b required 0 after %0d cycles", busy0, k);
    end
    step();
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1;
    a_len = 16'd10; a_req0 = 1'b1; c_req0 = 1'b1;
    repeat (3) step();
    n_vec++;
    if (st0 !== 8'h00 || data0 !== '0 || len0 !== 16'd0) begin
      n_bad++;
      $display("FAIL reset0: st=%b len=%0d required 0", st0, len0);
    end
    n_vec++;
    if (st1 !== 8'h00 || data1 !== '0 || len1 !== 16'd0) begin
      n_bad++;
      $display("FAIL reset1: st=%b len=%0d required 0", st1, len1);
    end
    rst0 = 1'b0; rst1 = 1'b0; a_req0 = 1'b0; c_req0 = 1'b0;
    step();
  endtask

  task automatic test_single();
    logic [DW-1:0] exp_d;
    exp_d = rand_data();
    a_data = exp_d; a_len = 16'd960; a_req0 = 1'b1;
    step();
    a_req0 = 1'b0;
    a_data = rand_data();
    n_vec++;
    if (st0 !== 8'b1_01_1_0000 || len0 !== 16'd960 || data0 !== exp_d) begin
      n_bad++;
      $display("FAIL single_grant: st=%b len=%0d data_lsw=%h required st=10110000 len=960 data_lsw=%h",
               st0, len0, data0[31:0], exp_d[31:0]);
    end
    repeat (8) step();
    n_vec++;
    if (st0 !== 8'b1_01_1_0000 || data0 !== exp_d) begin
      n_bad++;
      $display("FAIL single_hold: st=%b required 10110000", st0);
    end
    done0 = 1'b1;
    step();
    done0 = 1'b0;
    n_vec++;
    if (st0 !== 8'b0_00_1_1000) begin
      n_bad++;
      $display("FAIL single_ack: st=%b required 00011000", st0);
    end
    step();
    n_vec++;
    if (st0 !== 8'b0_00_1_0000) begin
      n_bad++;
      $display("FAIL single_ack_pulse: st=%b required 00010000", st0);
    end
    done0 = 1'b1;
    step();
    done0 = 1'b0;
    n_vec++;
    if (st0 !== 8'b0_00_1_0000) begin
      n_bad++;
      $display("FAIL stray_done_gap: st=%b required 00010000", st0);
    end
    repeat (61) step();
    n_vec++;
    if (busy0 !== 1'b1) begin
      n_bad++;
      $display("FAIL gap_last_cycle: busy=%b required 1", busy0);
    end
    step();
    n_vec++;
    if (busy0 !== 1'b0) begin
      n_bad++;
      $display("FAIL gap_end: busy=%b required 0", busy0);
    end
    done0 = 1'b1;
    step();
    done0 = 1'b0;
    n_vec++;
    if (st0 !== 8'h00) begin
      n_bad++;
      $display("FAIL stray_done_idle: st=%b required 00000000", st0);
    end
    step();
  endtask

  task automatic test_invalid();
    logic [15:0] lens [2];
    lens[0] = 16'd0; lens[1] = 16'd961;
    foreach (lens[i]) begin
      c_len = lens[i]; c_data = rand_data(); c_req0 = 1'b1;
      step();
      n_vec++;
      if (st0 !== 8'b0_00_0_0001) begin
        n_bad++;
        $display("FAIL invalid_err len=%0d: st=%b required 00000001", lens[i], st0);
      end
      step();
      c_req0 = 1'b0;
      n_vec++;
      if (st0 !== 8'h00) begin
        n_bad++;
        $display("FAIL invalid_no_repeat len=%0d: st=%b required 00000000", lens[i], st0);
      end
      step();
    end
  endtask

  task automatic test_timeout();
    for (int wd = 0; wd < 2; wd++) begin
      a_len = 16'($urandom_range(1, 960)); a_data = rand_data(); a_req0 = 1'b1;
      step();
      a_req0 = 1'b0;
      for (int i = 0; i < TMO; i++) begin
        n_vec++;
        if (valid0 !== 1'b1) begin
          n_bad++;
          $display("FAIL timeout_valid wait_cycle=%0d: valid=%b required 1", i, valid0);
        end
        if (wd == 1 && i == TMO - 1) done0 = 1'b1;
        step();
        done0 = 1'b0;
      end
      n_vec++;
      if (st0 !== ((wd == 1) ? 8'b0_00_1_1000 : 8'b0_00_1_0100)) begin
        n_bad++;
        $display("FAIL timeout_end done=%0d: st=%b", wd, st0);
      end
      wait_idle0();
    end
  endtask

  task automatic test_reset_wait();
    a_len = 16'd100; a_data = rand_data(); a_req0 = 1'b1;
    step();
    a_req0 = 1'b0;
    repeat (5) step();
    rst0 = 1'b1;
    step();
    rst0 = 1'b0;
    n_vec++;
    if (st0 !== 8'h00 || data0 !== '0 || len0 !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_wait: st=%b len=%0d required 0", st0, len0);
    end
    repeat (3) step();
    n_vec++;
    if (st0 !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_wait_after: st=%b required 00000000", st0);
    end
    a_req0 = 1'b1;
    step();
    a_req0 = 1'b0;
    n_vec++;
    if (st0 !== 8'b1_01_1_0000 || len0 !== 16'd100) begin
      n_bad++;
      $display("FAIL reset_regrant: st=%b len=%0d", st0, len0);
    end
    done0 = 1'b1;
    step();
    done0 = 1'b0;
    n_vec++;
    if (st0 !== 8'b0_00_1_1000) begin
      n_bad++;
      $display("FAIL reset_regrant_ack: st=%b required 00011000", st0);
    end
    wait_idle0();
  endtask

  task automatic test_burst();
    logic [1:0] exp [6];
    int k;
    exp[0] = 2'b01; exp[1] = 2'b01; exp[2] = 2'b01;
    exp[3] = 2'b01; exp[4] = 2'b10; exp[5] = 2'b01;
    rst1 = 1'b1;
    step();
    rst1 = 1'b0;
    a_len = 16'd200; c_len = 16'd20;
    a_req1 = 1'b1; c_req1 = 1'b1;
    for (int g = 0; g < 6; g++) begin
      k = 0;
      while (!valid1 && k < 20) begin
        step();
        k++;
      end
      n_vec++;
      if (grant1 !== exp[g] || valid1 !== 1'b1) begin
        n_bad++;
        $display("FAIL burst_grant %0d: grant=%b valid=%b required %b", g, grant1, valid1, exp[g]);
      end
      done1 = 1'b1;
      step();
      done1 = 1'b0;
      n_vec++;
      if ({a_ack1, c_ack1} !== {exp[g][0], exp[g][1]}) begin
        n_bad++;
        $display("FAIL burst_ack %0d: a_ack=%b c_ack=%b", g, a_ack1, c_ack1);
      end
    end
    a_req1 = 1'b0; c_req1 = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_random();
    int streak;
    bit ap, cp, selc, ok, got;
    int k;
    logic [15:0]   l;
    logic [DW-1:0] exp_d;
    logic [7:0]    exp_st;
    rst1 = 1'b1;
    step();
    rst1 = 1'b0;
    streak = 0;
    for (int it = 0; it < 40; it++) begin
      ap = 1'($urandom_range(0, 1));
      cp = 1'($urandom_range(0, 1));
      if (!ap && !cp) ap = 1'b1;
      a_data = rand_data(); c_data = rand_data();
      a_len = rand_len(); c_len = rand_len();
      selc  = cp && (!ap || streak >= MAXB);
      l     = selc ? c_len : a_len;
      ok    = (l >= 1) && (l <= DW / 8);
      exp_d = selc ? c_data : a_data;
      a_req1 = ap; c_req1 = cp;
      step();
      a_req1 = 1'b0; c_req1 = 1'b0;
      if (!ok) begin
        exp_st = {4'b0000, 1'b0, !selc, 1'b0, selc};
        n_vec++;
        if (st1 !== exp_st) begin
          n_bad++;
          $display("FAIL rand_err it=%0d len=%0d: st=%b required %b", it, l, st1, exp_st);
        end
        step();
      end else begin
        streak = selc ? 0 : ((streak + 1 > MAXB) ? MAXB : streak + 1);
        exp_st = {1'b1, selc, !selc, 1'b1, 4'b0000};
        n_vec++;
        if (st1 !== exp_st || data1 !== exp_d || len1 !== l) begin
          n_bad++;
          $display("FAIL rand_grant it=%0d: st=%b len=%0d required st=%b len=%0d", it, st1, len1, exp_st, l);
        end
        a_data = rand_data(); c_data = rand_data();
        k = $urandom_range(0, 130);
        for (int i = 0; i < TMO; i++) begin
          n_vec++;
          if (valid1 !== 1'b1) begin
            n_bad++;
            $display("FAIL rand_wait it=%0d cycle=%0d: valid=%b required 1", it, i, valid1);
          end
          if (i == k) done1 = 1'b1;
          step();
          done1 = 1'b0;
          if (i == k) break;
        end
        got = (k < TMO);
        exp_st = {4'b0000, !selc && got, !selc && !got, selc && got, selc && !got};
        n_vec++;
        if (st1 !== exp_st || data1 !== exp_d) begin
          n_bad++;
          $display("FAIL rand_end it=%0d done_at=%0d: st=%b required %b", it, k, st1, exp_st);
        end
        step();
      end
    end
  endtask

  initial begin
    a_data = '0; c_data = '0; a_len = '0; c_len = '0;
    rst0 = 1'b1; a_req0 = 1'b0; c_req0 = 1'b0; done0 = 1'b0;
    rst1 = 1'b1; a_req1 = 1'b0; c_req1 = 1'b0; done1 = 1'b0;
    step();
    test_reset();
    test_single();
    test_invalid();
    test_timeout();
    test_reset_wait();
    test_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
